mux_4t1_chk: RTL and testbench

- Parameterised 4-to-1 multiplexer with a registered output stage and a built-in equivalence self-check.
- Internally computes the select result two ways:
  - gate-level sum-of-products path (primary);
  - case-style selection path (reference).
- Flags any disagreement between the two paths in a sticky error register.
- Used wherever a selectable data lane is needed with on-line integrity monitoring.

---
 rtl/mux_4t1_chk.sv | 92 +++++++++
 tb/tb_mux_4t1_chk.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_4t1_chk.sv
// mux_4t1_chk: 4-to-1 multiplexer with a registered output and an on-line
// equivalence check between two independent implementations of the select.
//
// The primary result f is built from a one-hot decode of sel, gated against
// each lane and OR-ed together. A reference result is built separately with a
// conditional selection. Any bit that differs raises mismatch, which is
// captured into the sticky flag err_q.
//
// Parameters:
//   WIDTH    bit width of each data lane and of f / f_q (minimum 1)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high; clears f_q and err_q
//   a..d     data lanes, selected by sel = 00 / 01 / 10 / 11
//   sel      lane select, sel[1] is the MSB
//   en       load enable for f_q
//   err_clr  synchronous clear of err_q (loses to a simultaneous mismatch)
//   f        combinational mux result (primary path)
//   f_q      registered mux result
//   mismatch combinational disagreement between primary and reference paths
//   err_q    sticky registered mismatch flag

module mux_4t1_chk #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   input  logic             en,
   input  logic             err_clr,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] f_q,
   output logic             mismatch,
   output logic             err_q
);

   // One-hot decode of sel; bit n enables lane n (a, b, c, d).
   logic [3:0] dec;

   assign dec[0] = ~sel[1] & ~sel[0];
   assign dec[1] = ~sel[1] &  sel[0];
   assign dec[2] =  sel[1] & ~sel[0];
   assign dec[3] =  sel[1] &  sel[0];

   // Primary path: sum of products.
   assign f = ({WIDTH{dec[0]}} & a)
            | ({WIDTH{dec[1]}} & b)
            | ({WIDTH{dec[2]}} & c)
            | ({WIDTH{dec[3]}} & d);

   // Reference path, kept structurally distinct from the primary one so a
   // defect in either shows up as a disagreement.
   wire [WIDTH-1:0] ref_sel;

   assign ref_sel = sel[1] ? (sel[0] ? d : c)
                           : (sel[0] ? b : a);

   assign mismatch = |(f ^ ref_sel);

   logic [WIDTH-1:0] f_d;
   logic             err_d;

   always_comb begin
      f_d   = f_q;
      err_d = err_q;
      if (en) begin
         f_d = f;
      end
      // A fresh mismatch must never be lost, so set takes priority over clear.
      if (mismatch) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q   <= '0;
         err_q <= 1'b0;
      end else begin
         f_q   <= f_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_mux_4t1_chk.sv
// Self-checking bench for mux_4t1_chk: one WIDTH=1 and one WIDTH=8 instance,
// directed steps with a scoreboard queue holding the expected f_q values.

module tb_mux_4t1_chk;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       a1, b1, c1, d1;
   logic [1:0] sel1;
   logic       en1, err_clr1;
   logic       f1, f_q1, mismatch1, err_q1;

   logic [7:0] a8, b8, c8, d8;
   logic [1:0] sel8;
   logic       en8, err_clr8;
   logic [7:0] f8, f_q8;
   logic       mismatch8, err_q8;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0] q1[$];
   logic [7:0] q8[$];
   logic [7:0] model_fq8;

   always #2 clk = ~clk;

   mux_4t1_chk #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .a        (a1),
      .b        (b1),
      .c        (c1),
      .d        (d1),
      .sel      (sel1),
      .en       (en1),
      .err_clr  (err_clr1),
      .f        (f1),
      .f_q      (f_q1),
      .mismatch (mismatch1),
      .err_q    (err_q1)
   );

   mux_4t1_chk #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .a        (a8),
      .b        (b8),
      .c        (c8),
      .d        (d8),
      .sel      (sel8),
      .en       (en8),
      .err_clr  (err_clr8),
      .f        (f8),
      .f_q      (f_q8),
      .mismatch (mismatch8),
      .err_q    (err_q8)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // abcd = {a, b, c, d}; lane for sel s is abcd[3-s].
   task automatic step1(input string tag, input logic [3:0] abcd, input logic [1:0] s);
      logic       exp;
      logic [1:0] idx;
      @(negedge clk);
      {a1, b1, c1, d1} = abcd;
      sel1 = s;
      en1  = 1'b1;
      idx  = 2'd3 - s;
      exp  = abcd[idx];
      #1;
      check({tag, "_f"}, {7'd0, f1}, {7'd0, exp});
      check({tag, "_mismatch"}, {7'd0, mismatch1}, 8'd0);
      q1.push_back({7'd0, exp});
      @(posedge clk);
      #1;
      check({tag, "_f_q"}, {7'd0, f_q1}, q1.pop_front());
   endtask

   task automatic step8(input string tag, input logic [1:0] s, input logic e);
      logic [7:0] exp;
      @(negedge clk);
      sel8 = s;
      en8  = e;
      case (s)
         2'b00:   exp = a8;
         2'b01:   exp = b8;
         2'b10:   exp = c8;
         default: exp = d8;
      endcase
      #1;
      check({tag, "_f"}, f8, exp);
      check({tag, "_mismatch"}, {7'd0, mismatch8}, 8'd0);
      if (e) model_fq8 = exp;
      q8.push_back(model_fq8);
      @(posedge clk);
      #1;
      check({tag, "_f_q"}, f_q8, q8.pop_front());
   endtask

   initial begin
      {a1, b1, c1, d1} = 4'b0;
      sel1 = 2'b00; en1 = 1'b0; err_clr1 = 1'b0;
      a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
      sel8 = 2'b00; en8 = 1'b0; err_clr8 = 1'b0;
      model_fq8 = 8'h00;

      // Reset state.
      #1;
      check("rst_f_q1", {7'd0, f_q1}, 8'd0);
      check("rst_err_q1", {7'd0, err_q1}, 8'd0);
      check("rst_f_q8", f_q8, 8'd0);
      check("rst_err_q8", {7'd0, err_q8}, 8'd0);
      check("rst_f8_comb", f8, 8'hA5);
      @(negedge clk);
      rst = 1'b0;

      // Walk sel with a=0, b=1, c=0, d=1.
      step1("walk00", 4'b0101, 2'b00);
      step1("walk01", 4'b0101, 2'b01);
      step1("walk10", 4'b0101, 2'b10);
      step1("walk11", 4'b0101, 2'b11);
      check("walk_err_q1", {7'd0, err_q1}, 8'd0);

      // Exhaustive WIDTH=1.
      for (int i = 0; i < 64; i++) begin
         logic [5:0] v;
         v = 6'(i);
         step1("exh", v[5:2], v[1:0]);
      end
      check("exh_err_q1", {7'd0, err_q1}, 8'd0);

      // WIDTH=8 lanes, then hold with en=0.
      step8("w8_00", 2'b00, 1'b1);
      step8("w8_01", 2'b01, 1'b1);
      step8("w8_10", 2'b10, 1'b1);
      step8("w8_11", 2'b11, 1'b1);
      step8("w8_ld3c", 2'b01, 1'b1);
      step8("hold_10", 2'b10, 1'b0);
      step8("hold_00", 2'b00, 1'b0);
      step8("hold_11", 2'b11, 1'b0);

      // Error flag: corrupt the reference path for one cycle.
      @(negedge clk);
      sel8 = 2'b00;
      force dut8.ref_sel = 8'h00;
      #1;
      check("inj_mismatch", {7'd0, mismatch8}, 8'd1);
      @(posedge clk); #1;
      check("inj_err_set", {7'd0, err_q8}, 8'd1);
      @(negedge clk);
      release dut8.ref_sel;
      #1;
      check("rel_mismatch", {7'd0, mismatch8}, 8'd0);
      @(posedge clk); #1;
      check("err_sticky", {7'd0, err_q8}, 8'd1);
      @(negedge clk);
      err_clr8 = 1'b1;
      force dut8.ref_sel = 8'h00;
      @(posedge clk); #1;
      check("set_beats_clr", {7'd0, err_q8}, 8'd1);
      @(negedge clk);
      release dut8.ref_sel;
      @(posedge clk); #1;
      check("err_clr", {7'd0, err_q8}, 8'd0);
      @(negedge clk);
      err_clr8 = 1'b0;
      force dut8.ref_sel = 8'h00;
      @(posedge clk); #1;
      check("err_reset_again", {7'd0, err_q8}, 8'd1);
      @(negedge clk);
      release dut8.ref_sel;
      check("f_q8_during_inj", f_q8, 8'h3C);

      // Reset mid-operation: f_q8 holds 3C, err_q8 is 1.
      step8("pre_rst", 2'b01, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_f_q8", f_q8, 8'h00);
      check("mid_rst_err_q8", {7'd0, err_q8}, 8'd0);
      check("mid_rst_f8_comb", f8, 8'h3C);
      model_fq8 = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      step8("post_rst", 2'b10, 1'b1);
      check("post_rst_f_q8", f_q8, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
